// File: rtl/alu_pkg.sv
// Shared types for the ALU driver: opcode/state encodings and the instruction bundle.
// Index fields are carried at the widest supported width (IDX_W); users slice down to REG_AW.
// Optional opcode range check is enabled by ALU_DRIVER_OPCODE_CHECK_EN (see alu_driver).
package alu_pkg;

  // Widest register index carried in instr_t; supports NUM_REGS up to 128.
  localparam int unsigned IDX_W = 8;

  typedef enum logic [2:0] {
    ADD          = 3'b000,
    SUBTRACT     = 3'b001,
    MULTIPLY     = 3'b010,
    EQUALS       = 3'b011,
    GREATER_THAN = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } driver_state_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [IDX_W-1:0] src1;
    logic [IDX_W-1:0] src2;
    logic [IDX_W-1:0] dest;
  } instr_t;

  // Opcodes the ALU actually implements.
  function automatic logic is_valid_op(input logic [2:0] op);
    return (op <= GREATER_THAN);
  endfunction

endpackage

// File: rtl/alu_driver_regfile.sv
// Register file: NUM_REGS x 8-bit, two asynchronous read ports, one load and one writeback port.
// Reads are combinational (same-cycle writes are not visible until the next cycle).
// Writeback has priority over a load to the same index; different indices both commit.
module alu_driver_regfile #(
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rd1_addr_i,
  input  logic [REG_AW-1:0] rd2_addr_i,
  output logic [7:0]        rd1_data_o,
  output logic [7:0]        rd2_data_o,
  input  logic              load_en_i,
  input  logic [REG_AW-1:0] load_addr_i,
  input  logic [7:0]        load_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [7:0]        wb_data_i
);

  logic [7:0] regs_q [NUM_REGS];

  // Storage update; the writeback assignment comes last so it wins on an index collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (load_en_i) begin
        regs_q[load_addr_i] <= load_data_i;
      end
      if (wb_en_i) begin
        regs_q[wb_addr_i] <= wb_data_i;
      end
    end
  end

  assign rd1_data_o = regs_q[rd1_addr_i];
  assign rd2_data_o = regs_q[rd2_addr_i];

endmodule

// File: rtl/alu_driver.sv
// ALU driver: accepts register instructions, issues them to a combinational ALU, writes back and reports.
// Latency: accept at edge N, result valid after edge N+1 (seen by the consumer at edge N+2); 3-cycle throughput.
// Backpressure: instr_ready_out only in IDLE; result held until result_ready_in. Macro: ALU_DRIVER_OPCODE_CHECK_EN.
module alu_driver
  import alu_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [2:0]        instr_opcode_in,
  input  logic [REG_AW-1:0] instr_src1_in,
  input  logic [REG_AW-1:0] instr_src2_in,
  input  logic [REG_AW-1:0] instr_dest_in,
  input  logic              load_valid_in,
  input  logic [REG_AW-1:0] load_addr_in,
  input  logic [7:0]        load_data_in,
  output logic              alu_enable_out,
  output logic [2:0]        alu_opcode_out,
  output logic [7:0]        alu_input1_out,
  output logic [7:0]        alu_input2_out,
  input  logic [7:0]        alu_result_in,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic [7:0]        result_data_out,
  output logic [REG_AW-1:0] result_dest_out,
  output logic              error_out,
  output logic              busy_out
);

  driver_state_t     state_q, state_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic [7:0]        result_q, result_d;
  logic [7:0]        rd1_data, rd2_data;
  logic              bypass;
  instr_t            instr_w;
  logic              unused_idx_bits;

  // Pack the incoming instruction; index fields are zero-extended to the package width.
  always_comb begin
    instr_w.opcode = instr_opcode_in;
    instr_w.src1   = IDX_W'(instr_src1_in);
    instr_w.src2   = IDX_W'(instr_src2_in);
    instr_w.dest   = IDX_W'(instr_dest_in);
  end

  // Padding bits above REG_AW carry no information.
  assign unused_idx_bits = ^{instr_w.src1[IDX_W-1:REG_AW],
                             instr_w.src2[IDX_W-1:REG_AW],
                             instr_w.dest[IDX_W-1:REG_AW]};

  alu_driver_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk_i       (clock_in),
    .rst_i       (reset_in),
    .rd1_addr_i  (instr_w.src1[REG_AW-1:0]),
    .rd2_addr_i  (instr_w.src2[REG_AW-1:0]),
    .rd1_data_o  (rd1_data),
    .rd2_data_o  (rd2_data),
    .load_en_i   (load_valid_in),
    .load_addr_i (load_addr_in),
    .load_data_i (load_data_in),
    .wb_en_i     (state_q == ISSUE),
    .wb_addr_i   (dest_q),
    .wb_data_i   (alu_result_in)
  );

`ifdef ALU_DRIVER_OPCODE_CHECK_EN
  logic err_q, err_d;
  // Unsupported opcodes skip the ALU entirely and report an error.
  assign bypass = !is_valid_op(instr_w.opcode);
`else
  // Every opcode goes through the ALU; unsupported ones simply return 0.
  assign bypass = 1'b0;
`endif

  // Next-state and datapath latch logic for IDLE -> ISSUE -> RESPOND -> IDLE.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid_in) begin
          opcode_d = instr_w.opcode;
          dest_d   = instr_w.dest[REG_AW-1:0];
          op1_d    = rd1_data;
          op2_d    = rd2_data;
          if (bypass) begin
            state_d  = RESPOND;
            result_d = 8'h00;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
            err_d    = 1'b1;
`endif
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        result_d = alu_result_in;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
        err_d    = 1'b0;
`endif
        state_d  = RESPOND;
      end
      RESPOND: begin
        if (result_ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset aborts any in-flight instruction.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      opcode_q <= 3'd0;
      dest_q   <= '0;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      result_q <= 8'h00;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // ALU-facing outputs are forced to zero outside ISSUE so the ALU idles at 0.
  assign alu_enable_out   = (state_q == ISSUE);
  assign alu_opcode_out   = (state_q == ISSUE) ? opcode_q : 3'd0;
  assign alu_input1_out   = (state_q == ISSUE) ? op1_q : 8'h00;
  assign alu_input2_out   = (state_q == ISSUE) ? op2_q : 8'h00;

  assign instr_ready_out  = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign result_valid_out = (state_q == RESPOND);
  assign result_data_out  = result_q;
  assign result_dest_out  = dest_q;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
  assign error_out        = err_q;
`else
  assign error_out        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural combinational ALU attached.
module tb_alu_driver;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       instr_valid_in;
  logic       instr_ready_out;
  logic [2:0] instr_opcode_in;
  logic [2:0] instr_src1_in;
  logic [2:0] instr_src2_in;
  logic [2:0] instr_dest_in;
  logic       load_valid_in;
  logic [2:0] load_addr_in;
  logic [7:0] load_data_in;
  logic       alu_enable_out;
  logic [2:0] alu_opcode_out;
  logic [7:0] alu_input1_out;
  logic [7:0] alu_input2_out;
  logic [7:0] alu_result_in;
  logic       result_valid_out;
  logic       result_ready_in;
  logic [7:0] result_data_out;
  logic [2:0] result_dest_out;
  logic       error_out;
  logic       busy_out;

  int checks = 0;
  int errors = 0;

  always #5 clock_in = ~clock_in;

  alu_driver #(.NUM_REGS(8)) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .instr_valid_in   (instr_valid_in),
    .instr_ready_out  (instr_ready_out),
    .instr_opcode_in  (instr_opcode_in),
    .instr_src1_in    (instr_src1_in),
    .instr_src2_in    (instr_src2_in),
    .instr_dest_in    (instr_dest_in),
    .load_valid_in    (load_valid_in),
    .load_addr_in     (load_addr_in),
    .load_data_in     (load_data_in),
    .alu_enable_out   (alu_enable_out),
    .alu_opcode_out   (alu_opcode_out),
    .alu_input1_out   (alu_input1_out),
    .alu_input2_out   (alu_input2_out),
    .alu_result_in    (alu_result_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_data_out  (result_data_out),
    .result_dest_out  (result_dest_out),
    .error_out        (error_out),
    .busy_out         (busy_out)
  );

  // Behavioural ALU: 8-bit wrapping arithmetic, signed compares, 0 for unknown opcodes.
  always_comb begin
    alu_result_in = 8'h00;
    if (alu_enable_out) begin
      case (alu_opcode_out)
        3'd0: alu_result_in = alu_input1_out + alu_input2_out;
        3'd1: alu_result_in = alu_input1_out - alu_input2_out;
        3'd2: alu_result_in = alu_input1_out * alu_input2_out;
        3'd3: alu_result_in = {7'd0, alu_input1_out == alu_input2_out};
        3'd4: alu_result_in = {7'd0, $signed(alu_input1_out) > $signed(alu_input2_out)};
        default: alu_result_in = 8'h00;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    load_valid_in = 1'b1;
    load_addr_in  = a;
    load_data_in  = d;
    tick();
    load_valid_in = 1'b0;
  endtask

  task automatic drive_instr(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                             input logic [2:0] d);
    instr_valid_in  = 1'b1;
    instr_opcode_in = op;
    instr_src1_in   = s1;
    instr_src2_in   = s2;
    instr_dest_in   = d;
  endtask

  // Run one instruction to completion; hold the result for 'hold' extra cycles before taking it.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [2:0] d, input int hold,
                           output logic [7:0] res, output logic [2:0] dst, output logic ok);
    int n;
    ok = 1'b1;
    drive_instr(op, s1, s2, d);
    tick();
    instr_valid_in = 1'b0;
    n = 0;
    while (!result_valid_out && n < 10) begin
      tick();
      n++;
    end
    if (!result_valid_out) ok = 1'b0;
    repeat (hold) tick();
    res = result_data_out;
    dst = result_dest_out;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
  endtask

  // r0 is kept at 0, so ADD idx,r0 -> idx returns the register and rewrites it unchanged.
  task automatic read_reg(input logic [2:0] idx, output logic [7:0] val, output logic ok);
    logic [2:0] dst;
    run_instr(3'd0, idx, 3'd0, idx, 0, val, dst, ok);
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) tick();
    checks++;
    if (instr_ready_out !== 1'b1 || busy_out !== 1'b0 || result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b, required 1 0 0",
               instr_ready_out, busy_out, result_valid_out);
    end
    checks++;
    if (alu_enable_out !== 1'b0 || alu_opcode_out !== 3'd0 || alu_input1_out !== 8'h00 ||
        alu_input2_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_alu: en=%b op=%0d in1=%h in2=%h, required all 0",
               alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out);
    end
    checks++;
    if (result_data_out !== 8'h00 || result_dest_out !== 3'd0 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: data=%h dest=%0d err=%b, required 0 0 0",
               result_data_out, result_dest_out, error_out);
    end
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_add_latency();
    logic [7:0] v;
    logic ok;
    do_load(3'd1, 8'd100);
    do_load(3'd2, 8'd100);
    drive_instr(3'd0, 3'd1, 3'd2, 3'd3);
    tick();
    instr_valid_in = 1'b0;
    checks++;
    if (alu_enable_out !== 1'b1 || alu_opcode_out !== 3'd0 || alu_input1_out !== 8'd100 ||
        alu_input2_out !== 8'd100 || result_valid_out !== 1'b0 || instr_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL add_issue: en=%b op=%0d in1=%h in2=%h valid=%b ready=%b, required 1 0 64 64 0 0",
               alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
               result_valid_out, instr_ready_out);
    end
    tick();
    checks++;
    if (result_valid_out !== 1'b1 || result_data_out !== 8'hC8 || result_dest_out !== 3'd3 ||
        alu_enable_out !== 1'b0) begin
      errors++;
      $display("FAIL add_respond: valid=%b data=%h dest=%0d en=%b, required 1 c8 3 0",
               result_valid_out, result_data_out, result_dest_out, alu_enable_out);
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || instr_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL add_idle: busy=%b ready=%b, required 0 1", busy_out, instr_ready_out);
    end
    read_reg(3'd3, v, ok);
    checks++;
    if (!ok || v !== 8'hC8) begin
      errors++;
      $display("FAIL add_writeback: r3=%h ok=%b, required c8", v, ok);
    end
  endtask

  task automatic test_mul_stall();
    logic [7:0] v;
    logic [2:0] dst;
    logic ok;
    int bad;
    do_load(3'd4, 8'hFD);
    do_load(3'd5, 8'd5);
    drive_instr(3'd2, 3'd4, 3'd5, 3'd4);
    tick();
    instr_valid_in = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (result_valid_out !== 1'b1 || result_data_out !== 8'hF1 || result_dest_out !== 3'd4 ||
          instr_ready_out !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_hold: %0d unstable cycles (data=%h), required 0 with data f1",
               bad, result_data_out);
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    run_instr(3'd1, 3'd4, 3'd5, 3'd6, 0, v, dst, ok);
    checks++;
    if (!ok || v !== 8'hEC || dst !== 3'd6) begin
      errors++;
      $display("FAIL sub_after_mul: data=%h dest=%0d ok=%b, required ec 6", v, dst, ok);
    end
  endtask

  task automatic test_compare();
    logic [7:0] v;
    logic [2:0] dst;
    logic ok;
    do_load(3'd1, 8'hFF);
    do_load(3'd2, 8'h01);
    run_instr(3'd4, 3'd1, 3'd2, 3'd6, 0, v, dst, ok);
    checks++;
    if (!ok || v !== 8'h00) begin
      errors++;
      $display("FAIL gt_signed: data=%h ok=%b, required 00", v, ok);
    end
    run_instr(3'd3, 3'd1, 3'd1, 3'd6, 0, v, dst, ok);
    checks++;
    if (!ok || v !== 8'h01 || dst !== 3'd6) begin
      errors++;
      $display("FAIL eq_same_src: data=%h dest=%0d ok=%b, required 01 6", v, dst, ok);
    end
  endtask

  task automatic test_load_collision();
    logic [7:0] v;
    logic [2:0] dst;
    logic ok;
    do_load(3'd1, 8'd10);
    do_load(3'd2, 8'd20);
    drive_instr(3'd0, 3'd1, 3'd2, 3'd3);
    tick();
    instr_valid_in = 1'b0;
    // Load to r3 lands on the same edge as the writeback of the ADD.
    load_valid_in = 1'b1;
    load_addr_in  = 3'd3;
    load_data_in  = 8'd7;
    tick();
    load_valid_in = 1'b0;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    read_reg(3'd3, v, ok);
    checks++;
    if (!ok || v !== 8'h1E) begin
      errors++;
      $display("FAIL wb_over_load: r3=%h ok=%b, required 1e", v, ok);
    end
    // Load to r6 on the accept edge: the operand must be the old value.
    do_load(3'd6, 8'd9);
    drive_instr(3'd0, 3'd6, 3'd0, 3'd6);
    load_valid_in = 1'b1;
    load_addr_in  = 3'd6;
    load_data_in  = 8'h33;
    tick();
    instr_valid_in = 1'b0;
    // Load to a different index during the writeback edge must also commit.
    load_addr_in  = 3'd5;
    load_data_in  = 8'h44;
    tick();
    load_valid_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b1 || result_data_out !== 8'h09) begin
      errors++;
      $display("FAIL read_before_write: valid=%b data=%h, required 1 09",
               result_valid_out, result_data_out);
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    read_reg(3'd5, v, ok);
    checks++;
    if (!ok || v !== 8'h44) begin
      errors++;
      $display("FAIL load_other_idx: r5=%h ok=%b, required 44", v, ok);
    end
  endtask

  task automatic test_back_to_back();
    do_load(3'd1, 8'd1);
    do_load(3'd2, 8'd2);
    result_ready_in = 1'b1;
    drive_instr(3'd0, 3'd1, 3'd2, 3'd1);
    tick();
    checks++;
    if (alu_enable_out !== 1'b1 || alu_input1_out !== 8'd1) begin
      errors++;
      $display("FAIL b2b_first: en=%b in1=%h, required 1 01", alu_enable_out, alu_input1_out);
    end
    tick();
    checks++;
    if (result_valid_out !== 1'b1 || result_data_out !== 8'd3) begin
      errors++;
      $display("FAIL b2b_result1: valid=%b data=%h, required 1 03", result_valid_out, result_data_out);
    end
    tick();
    checks++;
    if (instr_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b busy=%b, required 1 0", instr_ready_out, busy_out);
    end
    tick();
    checks++;
    if (alu_enable_out !== 1'b1 || alu_input1_out !== 8'd3) begin
      errors++;
      $display("FAIL b2b_dependency: en=%b in1=%h, required 1 03", alu_enable_out, alu_input1_out);
    end
    tick();
    instr_valid_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b1 || result_data_out !== 8'd5) begin
      errors++;
      $display("FAIL b2b_result2: valid=%b data=%h, required 1 05", result_valid_out, result_data_out);
    end
    tick();
    result_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    logic [7:0] v;
    logic ok;
    int bad;
    do_load(3'd1, 8'd3);
    do_load(3'd2, 8'd5);
    do_load(3'd7, 8'h55);
    drive_instr(3'd0, 3'd1, 3'd2, 3'd7);
    tick();
    instr_valid_in = 1'b0;
    checks++;
    if (alu_enable_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_issue: en=%b, required 1", alu_enable_out);
    end
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if (alu_enable_out !== 1'b0 || alu_input1_out !== 8'h00 || alu_input2_out !== 8'h00 ||
        busy_out !== 1'b0 || instr_ready_out !== 1'b1 || result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: en=%b in1=%h in2=%h busy=%b ready=%b valid=%b, required 0 0 0 0 1 0",
               alu_enable_out, alu_input1_out, alu_input2_out, busy_out, instr_ready_out,
               result_valid_out);
    end
    #1 reset_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (result_valid_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_no_result: %0d cycles with valid/busy, required 0", bad);
    end
    read_reg(3'd7, v, ok);
    checks++;
    if (!ok || v !== 8'h00) begin
      errors++;
      $display("FAIL midrst_no_wb: r7=%h ok=%b, required 00", v, ok);
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] v;
    logic ok;
    do_load(3'd1, 8'd3);
    do_load(3'd2, 8'd4);
    do_load(3'd5, 8'h22);
    drive_instr(3'd6, 3'd1, 3'd2, 3'd5);
    tick();
    instr_valid_in = 1'b0;
`ifdef ALU_DRIVER_OPCODE_CHECK_EN
    checks++;
    if (alu_enable_out !== 1'b0 || result_valid_out !== 1'b1 || error_out !== 1'b1 ||
        result_data_out !== 8'h00 || result_dest_out !== 3'd5) begin
      errors++;
      $display("FAIL badop_bypass: en=%b valid=%b err=%b data=%h dest=%0d, required 0 1 1 00 5",
               alu_enable_out, result_valid_out, error_out, result_data_out, result_dest_out);
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    read_reg(3'd5, v, ok);
    checks++;
    if (!ok || v !== 8'h22) begin
      errors++;
      $display("FAIL badop_no_wb: r5=%h ok=%b, required 22", v, ok);
    end
`else
    checks++;
    if (alu_enable_out !== 1'b1 || alu_opcode_out !== 3'd6 || result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL badop_issue: en=%b op=%0d valid=%b, required 1 6 0",
               alu_enable_out, alu_opcode_out, result_valid_out);
    end
    tick();
    checks++;
    if (alu_enable_out !== 1'b0 || result_valid_out !== 1'b1 || error_out !== 1'b0 ||
        result_data_out !== 8'h00) begin
      errors++;
      $display("FAIL badop_respond: en=%b valid=%b err=%b data=%h, required 0 1 0 00",
               alu_enable_out, result_valid_out, error_out, result_data_out);
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    read_reg(3'd5, v, ok);
    checks++;
    if (!ok || v !== 8'h00) begin
      errors++;
      $display("FAIL badop_wb_zero: r5=%h ok=%b, required 00", v, ok);
    end
`endif
  endtask

  initial begin
    reset_in        = 1'b1;
    instr_valid_in  = 1'b0;
    instr_opcode_in = 3'd0;
    instr_src1_in   = 3'd0;
    instr_src2_in   = 3'd0;
    instr_dest_in   = 3'd0;
    load_valid_in   = 1'b0;
    load_addr_in    = 3'd0;
    load_data_in    = 8'h00;
    result_ready_in = 1'b0;
    test_reset();
    test_add_latency();
    test_mul_stall();
    test_compare();
    test_load_collision();
    test_back_to_back();
    test_reset_mid_issue();
    test_bad_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
